// File: rtl/if_fetch.sv
// if_fetch: fetch stage between the PC register and IF/ID. It issues PCs on a req/gnt/rvalid
// bus, buffers the in-order responses and discards stale ones after a jump. Option macro: IF_MISALIGN_CHK_EN.
module if_fetch #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       FIFO_DEPTH = 2,
   parameter logic [DATA_W-1:0] NOP_INST   = DATA_W'(32'h0000_0013)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              jump_flag,
   output logic              ibus_req,
   output logic [ADDR_W-1:0] ibus_addr,
   input  logic              ibus_gnt,
   input  logic              ibus_rvalid,
   input  logic [DATA_W-1:0] ibus_rdata,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_valid,
   input  logic              inst_ready
`ifdef IF_MISALIGN_CHK_EN
   ,
   output logic              inst_fault
`endif
);

   localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   OCC_MAX = (CNT_W+1)'(FIFO_DEPTH);

   // data FIFO: returned words with the address they were fetched from
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
`ifdef IF_MISALIGN_CHK_EN
   logic              r_fifo_fault [FIFO_DEPTH];
`endif
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   // address queue: one entry per granted, not yet answered request
   logic [ADDR_W-1:0] r_aq_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_aq_wptr;
   logic [PTR_W-1:0]  r_aq_rptr;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_discard;
   logic [ADDR_W-1:0] r_last_addr;

   logic [CNT_W:0]    w_occupancy;
   logic              w_credit;
   logic              w_misalign;
   logic              w_fault_take;
   logic              w_grant;
   logic              w_drop;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_push_data;
   logic [ADDR_W-1:0] w_push_addr;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [CNT_W-1:0]  w_out_nxt;
   logic [CNT_W-1:0]  w_discard_nxt;

   assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_credit    = (w_occupancy < OCC_MAX);

`ifdef IF_MISALIGN_CHK_EN
   // A fault entry bypasses the bus, so it waits until nothing is in flight to keep order.
   assign w_misalign   = pc_valid & (pc_in[1:0] != 2'b00);
   assign w_fault_take = w_misalign & w_credit & ~jump_flag & ~rst_n & (r_outstanding == '0);
`else
   assign w_misalign   = 1'b0;
   assign w_fault_take = 1'b0;
`endif

   assign ibus_req  = pc_valid & w_credit & ~jump_flag & ~w_misalign & ~rst_n;
   assign ibus_addr = pc_in;
   assign w_grant   = ibus_req & ibus_gnt;
   assign pc_ready  = w_grant | w_fault_take;

   assign w_drop      = (r_discard != '0);
   assign w_push      = (ibus_rvalid & ~w_drop & ~jump_flag) | w_fault_take;
   assign w_pop       = inst_valid & inst_ready;
   assign w_push_data = w_fault_take ? NOP_INST : ibus_rdata;
   assign w_push_addr = w_fault_take ? pc_in : r_aq_addr[r_aq_rptr];

   always_comb begin
      // NOTE: every target gets its default first, so no path through this block infers a latch.
      w_count_nxt   = r_count;
      w_out_nxt     = r_outstanding;
      w_discard_nxt = r_discard;

      if (jump_flag)
         w_count_nxt = '0;
      else if (w_push && !w_pop)
         w_count_nxt = r_count + CNT_ONE;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - CNT_ONE;

      if (w_grant && !ibus_rvalid)
         w_out_nxt = r_outstanding + CNT_ONE;
      else if (!w_grant && ibus_rvalid)
         w_out_nxt = r_outstanding - CNT_ONE;

      // everything still in flight after this edge belongs to the old path
      if (jump_flag)
         w_discard_nxt = ibus_rvalid ? (r_outstanding - CNT_ONE) : r_outstanding;
      else if (ibus_rvalid && w_drop)
         w_discard_nxt = r_discard - CNT_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_aq_wptr     <= '0;
         r_aq_rptr     <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_last_addr   <= '0;
      end else begin
         r_count       <= w_count_nxt;
         r_outstanding <= w_out_nxt;
         r_discard     <= w_discard_nxt;
         r_last_addr   <= inst_addr_o;
         if (jump_flag) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         end
         if (w_grant)     r_aq_wptr <= r_aq_wptr + PTR_ONE;
         if (ibus_rvalid) r_aq_rptr <= r_aq_rptr + PTR_ONE;
      end
   end

   // NOTE: storage arrays carry no reset; the counters alone decide which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wptr] <= w_push_data;
         r_fifo_addr[r_wptr] <= w_push_addr;
`ifdef IF_MISALIGN_CHK_EN
         r_fifo_fault[r_wptr] <= w_fault_take;
`endif
      end
      if (w_grant) r_aq_addr[r_aq_wptr] <= pc_in;
   end

   assign inst_valid  = (r_count != '0);
   assign inst_o      = inst_valid ? r_fifo_data[r_rptr] : NOP_INST;
   assign inst_addr_o = inst_valid ? r_fifo_addr[r_rptr] : r_last_addr;
`ifdef IF_MISALIGN_CHK_EN
   assign inst_fault  = inst_valid & r_fifo_fault[r_rptr];
`endif

   a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst_n)
      ibus_rvalid |-> (r_outstanding != '0));
   a_occupancy_bounded: assert property (@(posedge clk) disable iff (rst_n)
      w_occupancy <= OCC_MAX);

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus for if_fetch with a queue-based reference model,
// a PC/bus responder and per-cycle output comparison at the falling edge.
module tb_if_fetch;

   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_valid;
   logic              pc_ready;
   logic              jump_flag;
   logic              ibus_req;
   logic [ADDR_W-1:0] ibus_addr;
   logic              ibus_gnt;
   logic              ibus_rvalid;
   logic [DATA_W-1:0] ibus_rdata;
   logic [DATA_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              inst_valid;
   logic              inst_ready;

   if_fetch #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .jump_flag(jump_flag), .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .inst_o(inst_o),
      .inst_addr_o(inst_addr_o), .inst_valid(inst_valid), .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // instruction memory contents seen by the bus
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hCAFE_0000;
   endfunction

   function automatic int ix(input int c);
      return c % 1024;
   endfunction

   // ---------------- bus responder and PC register ----------------
   typedef struct {
      logic [31:0] addr;
      int          ready;
   } bus_t;
   bus_t        bus_q[$];
   int          cyc = 0;
   logic        resp_hold = 1'b0;
   int          resp_lat = 1;
   logic [31:0] jump_target = '0;
   logic [31:0] pc_nxt;

   task automatic tick();
      @(negedge clk);
      pc_nxt = pc_in;
      if (rst_n) begin
         bus_q.delete();
      end else begin
         if (ibus_req && ibus_gnt) bus_q.push_back('{addr: ibus_addr, ready: cyc + resp_lat});
         if (jump_flag)     pc_nxt = jump_target;
         else if (pc_ready) pc_nxt = pc_in + 32'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
      pc_in     = pc_nxt;
      jump_flag = 1'b0;
      if (!rst_n && !resp_hold && bus_q.size() > 0 && bus_q[0].ready <= cyc) begin
         ibus_rvalid = 1'b1;
         ibus_rdata  = memf(bus_q[0].addr);
         void'(bus_q.pop_front());
      end else begin
         ibus_rvalid = 1'b0;
         ibus_rdata  = '0;
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } fl_t;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;
   fl_t         m_fl[$];
   ent_t        m_out[$];
   ent_t        consumed[$];
   logic [31:0] m_last;
   fl_t         m_f;
   bit          e_credit, e_req, e_rdy, e_valid;
   logic [31:0] e_inst, e_iaddr;
   int          k;

   logic        tr_valid  [1024];
   logic        tr_req    [1024];
   logic        tr_rdy    [1024];
   logic [31:0] tr_iaddr  [1024];
   logic [31:0] tr_inst   [1024];
   logic [31:0] tr_baddr  [1024];

   function automatic logic [31:0] got_addr(input int i);
      return (i < consumed.size()) ? consumed[i].addr : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] got_data(input int i);
      return (i < consumed.size()) ? consumed[i].data : 32'hDEAD_BEEF;
   endfunction

   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst_n) begin
            m_fl.delete();
            m_out.delete();
            m_last = '0;
         end else begin
            e_credit = (m_out.size() + m_fl.size()) < DEPTH;
            e_req    = pc_valid && e_credit && !jump_flag;
            e_rdy    = e_req && ibus_gnt;
            e_valid  = (m_out.size() != 0);
            e_inst   = NOP;
            e_iaddr  = m_last;
            if (e_valid) begin
               e_inst  = m_out[0].data;
               e_iaddr = m_out[0].addr;
            end
            check("ibus_req",    32'(ibus_req),   32'(e_req));
            check("pc_ready",    32'(pc_ready),   32'(e_rdy));
            check("ibus_addr",   ibus_addr,       pc_in);
            check("inst_valid",  32'(inst_valid), 32'(e_valid));
            check("inst_o",      inst_o,          e_inst);
            check("inst_addr_o", inst_addr_o,     e_iaddr);

            k = ix(cyc);
            tr_valid[k] = inst_valid;
            tr_req[k]   = ibus_req;
            tr_rdy[k]   = pc_ready;
            tr_iaddr[k] = inst_addr_o;
            tr_inst[k]  = inst_o;
            tr_baddr[k] = ibus_addr;

            m_last = e_iaddr;
            if (jump_flag) begin
               m_out.delete();
               if (ibus_rvalid && m_fl.size() > 0) void'(m_fl.pop_front());
               foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            end else begin
               if (e_valid && inst_ready) begin
                  consumed.push_back(m_out[0]);
                  void'(m_out.pop_front());
               end
               if (ibus_rvalid && m_fl.size() > 0) begin
                  m_f = m_fl.pop_front();
                  if (!m_f.stale) m_out.push_back('{addr: m_f.addr, data: memf(m_f.addr)});
               end
               if (e_rdy) m_fl.push_back('{addr: pc_in, stale: 1'b0});
            end
         end
      end
   end

   task automatic drain();
      pc_valid   = 1'b0;
      inst_ready = 1'b1;
      resp_hold  = 1'b0;
      repeat (8) tick();
      check("drain_empty", 32'(inst_valid), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- directed tests ----------------
   int c0;

   initial begin : stim
      rst_n       = 1'b1;
      pc_in       = '0;
      pc_valid    = 1'b1;
      jump_flag   = 1'b0;
      ibus_gnt    = 1'b1;
      ibus_rvalid = 1'b0;
      ibus_rdata  = '0;
      inst_ready  = 1'b0;
      #1;
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_o",     inst_o,          NOP);
      check("rst_inst_addr",  inst_addr_o,     32'd0);
      check("rst_ibus_req",   32'(ibus_req),   32'd0);
      tick();
      tick();
      rst_n = 1'b0;

      // in-order stream 0x0, 0x4, 0x8 with single-cycle response latency
      pc_in = 32'h0; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b1;
      consumed.delete();
      c0 = cyc;
      repeat (8) tick();
      check("t1_valid_c1",  32'(tr_valid[ix(c0+1)]), 32'd0);
      check("t1_valid_c2",  32'(tr_valid[ix(c0+2)]), 32'd1);
      check("t1_addr_c2",   tr_iaddr[ix(c0+2)],      32'h0);
      check("t1_inst_c2",   tr_inst[ix(c0+2)],       32'hCAFE_0000);
      check("t1_nocredit",  32'(tr_rdy[ix(c0+2)]),   32'd0);
      check("t1_addr0",     got_addr(0),             32'h0);
      check("t1_addr1",     got_addr(1),             32'h4);
      check("t1_addr2",     got_addr(2),             32'h8);
      check("t1_data1",     got_data(1),             32'hCAFE_0004);
      drain();

      // back-pressure: two grants fill credit, one pop frees it
      pc_in = 32'h200; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b0;
      c0 = cyc;
      repeat (3) tick();
      inst_ready = 1'b1;
      repeat (2) tick();
      check("t2_rdy_c0",   32'(tr_rdy[ix(c0)]),    32'd1);
      check("t2_rdy_c1",   32'(tr_rdy[ix(c0+1)]),  32'd1);
      check("t2_rdy_c2",   32'(tr_rdy[ix(c0+2)]),  32'd0);
      check("t2_req_c2",   32'(tr_req[ix(c0+2)]),  32'd0);
      check("t2_rdy_c3",   32'(tr_rdy[ix(c0+3)]),  32'd0);
      check("t2_head_c3",  tr_iaddr[ix(c0+3)],     32'h200);
      check("t2_rdy_c4",   32'(tr_rdy[ix(c0+4)]),  32'd1);
      drain();

      // grant withheld for three cycles
      pc_in = 32'h300; pc_valid = 1'b1; ibus_gnt = 1'b0; inst_ready = 1'b1;
      consumed.delete();
      c0 = cyc;
      repeat (3) tick();
      ibus_gnt = 1'b1;
      repeat (4) tick();
      check("t3_rdy_c0",   32'(tr_rdy[ix(c0)]),    32'd0);
      check("t3_rdy_c2",   32'(tr_rdy[ix(c0+2)]),  32'd0);
      check("t3_req_c1",   32'(tr_req[ix(c0+1)]),  32'd1);
      check("t3_baddr_c2", tr_baddr[ix(c0+2)],     32'h300);
      check("t3_rdy_c3",   32'(tr_rdy[ix(c0+3)]),  32'd1);
      check("t3_first",    got_addr(0),            32'h300);
      drain();

      // jump with two requests in flight, responses arriving after the jump
      resp_hold = 1'b1;
      pc_in = 32'h400; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b1;
      consumed.delete();
      c0 = cyc;
      repeat (2) tick();
      jump_flag = 1'b1; jump_target = 32'h100;
      tick();
      resp_hold = 1'b0;
      repeat (6) tick();
      check("t4_valid_c3", 32'(tr_valid[ix(c0+3)]), 32'd0);
      check("t4_req_c5",   32'(tr_req[ix(c0+5)]),   32'd1);
      check("t4_baddr_c5", tr_baddr[ix(c0+5)],      32'h100);
      check("t4_first",    got_addr(0),             32'h100);
      check("t4_data",     got_data(0),             32'hCAFE_0100);
      drain();

      // jump on a full FIFO, then a back-to-back jump that must suppress the request
      pc_in = 32'h500; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b0;
      consumed.delete();
      c0 = cyc;
      repeat (4) tick();
      jump_flag = 1'b1; jump_target = 32'h600;
      tick();
      jump_flag = 1'b1; jump_target = 32'h680; inst_ready = 1'b1;
      repeat (5) tick();
      check("t5a_full",    32'(tr_valid[ix(c0+4)]), 32'd1);
      check("t5a_flushed", 32'(tr_valid[ix(c0+5)]), 32'd0);
      check("t5a_jmp_req", 32'(tr_req[ix(c0+5)]),   32'd0);
      check("t5a_first",   got_addr(0),             32'h680);
      drain();

      // jump coincident with rvalid while two requests are outstanding
      resp_hold = 1'b1;
      pc_in = 32'h700; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b1;
      consumed.delete();
      c0 = cyc;
      tick();
      resp_hold = 1'b0;
      tick();
      jump_flag = 1'b1; jump_target = 32'h800;
      tick();
      repeat (6) tick();
      check("t5b_valid_c3", 32'(tr_valid[ix(c0+3)]), 32'd0);
      check("t5b_valid_c4", 32'(tr_valid[ix(c0+4)]), 32'd0);
      check("t5b_valid_c5", 32'(tr_valid[ix(c0+5)]), 32'd1);
      check("t5b_addr_c5",  tr_iaddr[ix(c0+5)],      32'h800);
      check("t5b_rdy_c3",   32'(tr_rdy[ix(c0+3)]),   32'd1);
      check("t5b_first",    got_addr(0),             32'h800);
      drain();

      // asynchronous reset in the middle of a stream
      pc_in = 32'h900; pc_valid = 1'b1; ibus_gnt = 1'b1; inst_ready = 1'b1;
      repeat (5) tick();
      #2;
      rst_n = 1'b1;
      ibus_rvalid = 1'b0;
      #1;
      check("t6_inst_valid", 32'(inst_valid), 32'd0);
      check("t6_inst_o",     inst_o,          NOP);
      check("t6_inst_addr",  inst_addr_o,     32'd0);
      check("t6_ibus_req",   32'(ibus_req),   32'd0);
      check("t6_pc_ready",   32'(pc_ready),   32'd0);
      repeat (2) tick();
      rst_n = 1'b0;
      pc_in = 32'hA00;
      consumed.delete();
      c0 = cyc;
      repeat (6) tick();
      check("t6_valid_c2", 32'(tr_valid[ix(c0+2)]), 32'd1);
      check("t6_addr_c2",  tr_iaddr[ix(c0+2)],      32'hA00);
      check("t6_first",    got_addr(0),             32'hA00);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
